// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for the fetch-side predictor.
// Lookup is combinational. Training from EX is registered. Two free-running counters track resolved branches and mispredicts.
module branch_predictor #(
    parameter int ENTRIES = 64,
    localparam int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    logic                  r_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [31:0]           r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];
    logic [31:0]           r_branchCount;
    logic [31:0]           r_mispredictCount;

    logic [INDEX_BITS-1:0] w_ifIdx;
    logic [TAG_BITS-1:0]   w_ifTag;
    logic                  w_ifHit;
    logic [INDEX_BITS-1:0] w_updIdx;
    logic [TAG_BITS-1:0]   w_updTag;
    logic                  w_updHit;
    logic                  w_mispredict;
    logic                  w_unusedLowBits;

    // Instructions are word aligned, so the byte-offset bits carry no information.
    assign w_unusedLowBits = ^{if_pc[1:0], upd_pc[1:0]};

    assign w_ifIdx  = if_pc[INDEX_BITS+1:2];
    assign w_ifTag  = if_pc[31:INDEX_BITS+2];
    assign w_updIdx = upd_pc[INDEX_BITS+1:2];
    assign w_updTag = upd_pc[31:INDEX_BITS+2];

    assign w_ifHit  = r_valid[w_ifIdx] && (r_tag[w_ifIdx] == w_ifTag);
    assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

    assign pred_taken  = w_ifHit && r_ctr[w_ifIdx][1];
    assign pred_target = pred_taken ? r_target[w_ifIdx] : 32'd0;

    // A correct direction with a wrong target still needs a redirect.
    assign w_mispredict = upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    assign mispredict   = w_mispredict;

    assign branch_count     = r_branchCount;
    assign mispredict_count = r_mispredictCount;

    // Reset wins over a concurrent update. A not-taken miss leaves the table untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= 2'b00;
            end
            r_branchCount     <= 32'd0;
            r_mispredictCount <= 32'd0;
        end else if (upd_valid) begin
            r_branchCount <= r_branchCount + 32'd1;
            if (w_mispredict) begin
                r_mispredictCount <= r_mispredictCount + 32'd1;
            end
            if (w_updHit) begin
                if (upd_taken) begin
                    if (r_ctr[w_updIdx] != 2'b11) begin
                        r_ctr[w_updIdx] <= r_ctr[w_updIdx] + 2'b01;
                    end
                    r_target[w_updIdx] <= upd_target;
                end else if (r_ctr[w_updIdx] != 2'b00) begin
                    r_ctr[w_updIdx] <= r_ctr[w_updIdx] - 2'b01;
                end
            end else if (upd_taken) begin
                r_valid[w_updIdx]  <= 1'b1;
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= upd_target;
                r_ctr[w_updIdx]    <= 2'b10;
            end
        end
    end

endmodule
